// File: rtl/memr_pkg.sv
// Shared types and constants for the memristor program/verify sequencer.
// Optional build macro used by the sequencer: MEMR_READ_FILTER_EN.
package memr_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RD_SETTLE = 3'd1,
    RD_SAMPLE = 3'd2,
    PULSE     = 3'd3,
    DONE      = 3'd4
  } memr_state_t;

  localparam logic MEMR_TGT_SET   = 1'b1;
  localparam logic MEMR_TGT_RESET = 1'b0;

  // Two-out-of-three vote used to filter noisy sense comparator reads.
  function automatic logic memr_majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/memr_cyc_timer.sv
// Loadable down-counter with a zero flag; times pulse, settle and sample windows.
module memr_cyc_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt_r;

  // Load a new duration, otherwise count down and park at zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (load) begin
      cnt_r <= load_val;
    end else if (cnt_r != '0) begin
      cnt_r <= cnt_r - W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign zero = (cnt_r == '0);

endmodule

// File: rtl/memristor_prog_verify.sv
// Program/verify sequencer for one memristor cell: pre-read, then alternate
// SET/RESET pulses with verify reads until the cell matches or tries run out.
// Build macro MEMR_READ_FILTER_EN: 3-sample majority read instead of 1 sample.
module memristor_prog_verify
  import memr_pkg::*;
#(
  parameter int PULSE_CYC  = 4,
  parameter int SETTLE_CYC = 2,
  parameter int MAX_TRIES  = 8,
  parameter int CNT_W      = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_target,
  output logic             set_pulse,
  output logic             reset_pulse,
  output logic             read_en,
  input  logic             sense_in,
  output logic             done_valid,
  output logic             done_ok,
  output logic [CNT_W-1:0] done_tries
);

`ifdef MEMR_READ_FILTER_EN
  localparam int SAMPLE_CYC = 3;
`else
  localparam int SAMPLE_CYC = 1;
`endif
  localparam int TMR_MAX0 = (PULSE_CYC > SETTLE_CYC) ? PULSE_CYC : SETTLE_CYC;
  localparam int TMR_MAX  = (TMR_MAX0 > SAMPLE_CYC) ? TMR_MAX0 : SAMPLE_CYC;
  localparam int TMR_W    = $clog2(TMR_MAX + 1);
  localparam logic [CNT_W-1:0] MAX_T = CNT_W'(MAX_TRIES);

  memr_state_t      state_r;
  logic             target_r;
  logic [CNT_W-1:0] tries_r;
  logic             tmr_load_s;
  logic [TMR_W-1:0] tmr_val_s;
  logic             tmr_zero_s;
  logic             sample_last_s;
  logic             sensed_s;
  logic             match_s;
  logic             limit_s;

`ifdef MEMR_READ_FILTER_EN
  logic [1:0] samp_r;

  // Keep the two earlier samples of the read window for the majority vote.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      samp_r <= 2'b00;
    end else if (state_r == RD_SAMPLE) begin
      samp_r <= {samp_r[0], sense_in};
    end else begin
      samp_r <= samp_r;
    end
  end
`endif

  // Read decision: on the last sample cycle, compare the sensed level to the target.
  always_comb begin
`ifdef MEMR_READ_FILTER_EN
    sample_last_s = tmr_zero_s;
    sensed_s      = memr_majority3(samp_r[1], samp_r[0], sense_in);
`else
    sample_last_s = 1'b1;
    sensed_s      = sense_in;
`endif
    match_s = (sensed_s == target_r);
    limit_s = (tries_r >= MAX_T);
  end

  // Timer reload on each timed-state entry. Entering RD_SETTLE from PULSE loads
  // one extra cycle: that first cycle is the all-low gap before read bias.
  always_comb begin
    tmr_load_s = 1'b0;
    tmr_val_s  = '0;
    case (state_r)
      IDLE: begin
        if (req_valid && req_ready) begin
          tmr_load_s = 1'b1;
          tmr_val_s  = TMR_W'(SETTLE_CYC - 1);
        end else begin
          tmr_load_s = 1'b0;
        end
      end
      RD_SETTLE: begin
        if (tmr_zero_s) begin
          tmr_load_s = 1'b1;
          tmr_val_s  = TMR_W'(SAMPLE_CYC - 1);
        end else begin
          tmr_load_s = 1'b0;
        end
      end
      RD_SAMPLE: begin
        if (sample_last_s && !match_s && !limit_s) begin
          tmr_load_s = 1'b1;
          tmr_val_s  = TMR_W'(PULSE_CYC - 1);
        end else begin
          tmr_load_s = 1'b0;
        end
      end
      PULSE: begin
        if (tmr_zero_s) begin
          tmr_load_s = 1'b1;
          tmr_val_s  = TMR_W'(SETTLE_CYC);
        end else begin
          tmr_load_s = 1'b0;
        end
      end
      default: begin
        tmr_load_s = 1'b0;
      end
    endcase
  end

  memr_cyc_timer #(.W(TMR_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load_s),
    .load_val (tmr_val_s),
    .zero     (tmr_zero_s)
  );

  // Sequencer FSM; every output is a register updated on state entry/exit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      target_r    <= MEMR_TGT_RESET;
      tries_r     <= '0;
      req_ready   <= 1'b0;
      set_pulse   <= 1'b0;
      reset_pulse <= 1'b0;
      read_en     <= 1'b0;
      done_valid  <= 1'b0;
      done_ok     <= 1'b0;
      done_tries  <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (req_valid && req_ready) begin
            target_r  <= req_target;
            tries_r   <= '0;
            req_ready <= 1'b0;
            read_en   <= 1'b1;
            state_r   <= RD_SETTLE;
          end else begin
            req_ready <= 1'b1;
          end
        end
        RD_SETTLE: begin
          read_en <= 1'b1;
          if (tmr_zero_s) begin
            state_r <= RD_SAMPLE;
          end
        end
        RD_SAMPLE: begin
          if (sample_last_s) begin
            read_en <= 1'b0;
            if (match_s || limit_s) begin
              done_valid <= 1'b1;
              done_ok    <= match_s;
              done_tries <= tries_r;
              state_r    <= DONE;
            end else begin
              tries_r     <= (tries_r < MAX_T) ? tries_r + CNT_W'(1) : tries_r;
              set_pulse   <= (target_r == MEMR_TGT_SET);
              reset_pulse <= (target_r == MEMR_TGT_RESET);
              state_r     <= PULSE;
            end
          end
        end
        PULSE: begin
          if (tmr_zero_s) begin
            set_pulse   <= 1'b0;
            reset_pulse <= 1'b0;
            state_r     <= RD_SETTLE;
          end
        end
        DONE: begin
          done_valid <= 1'b0;
          req_ready  <= 1'b1;
          state_r    <= IDLE;
        end
        default: begin
          state_r     <= IDLE;
          req_ready   <= 1'b0;
          set_pulse   <= 1'b0;
          reset_pulse <= 1'b0;
          read_en     <= 1'b0;
          done_valid  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_memristor_prog_verify.sv
// Self-checking bench for memristor_prog_verify: table vectors, random requests
// against a cell/outcome model, and hand sequences for reset and read sampling.
module tb_memristor_prog_verify;

  localparam int PULSE_CYC  = 4;
  localparam int SETTLE_CYC = 2;
  localparam int MAX_TRIES  = 8;
  localparam int CNT_W      = 4;
`ifdef MEMR_READ_FILTER_EN
  localparam int SAMPLE_CYC = 3;
`else
  localparam int SAMPLE_CYC = 1;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req_valid = 1'b0;
  logic req_target = 1'b0;
  logic sense_in;
  logic req_ready, set_pulse, reset_pulse, read_en, done_valid, done_ok;
  logic [CNT_W-1:0] done_tries;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  memristor_prog_verify #(
    .PULSE_CYC(PULSE_CYC), .SETTLE_CYC(SETTLE_CYC), .MAX_TRIES(MAX_TRIES), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_target(req_target), .set_pulse(set_pulse), .reset_pulse(reset_pulse),
    .read_en(read_en), .sense_in(sense_in), .done_valid(done_valid),
    .done_ok(done_ok), .done_tries(done_tries)
  );

  // Output activity bookkeeping, sampled on the falling edge.
  int excl_viol = 0, gap_viol = 0, set_cyc = 0, reset_cyc = 0, read_cyc = 0, dv_cnt = 0;
  int set_bursts = 0, reset_bursts = 0;
  logic prev_set = 1'b0, prev_reset = 1'b0;

  always @(negedge clk) begin
    if ((set_pulse && reset_pulse) || (set_pulse && read_en) || (reset_pulse && read_en))
      excl_viol <= excl_viol + 1;
    if ((prev_set || prev_reset) && read_en) gap_viol <= gap_viol + 1;
    if (set_pulse) set_cyc <= set_cyc + 1;
    if (reset_pulse) reset_cyc <= reset_cyc + 1;
    if (read_en) read_cyc <= read_cyc + 1;
    if (done_valid) dv_cnt <= dv_cnt + 1;
    if (prev_set && !set_pulse) set_bursts <= set_bursts + 1;
    if (prev_reset && !reset_pulse) reset_bursts <= reset_bursts + 1;
    prev_set <= set_pulse;
    prev_reset <= reset_pulse;
  end

  // Cell model: flips to the target after 'need' completed target-polarity bursts.
  logic cell_tgt = 1'b0, cell_init = 1'b0, force_en = 1'b0, force_val = 1'b0;
  int need = 0, burst_base = 0;
  int tgt_bursts;
  assign tgt_bursts = cell_tgt ? set_bursts : reset_bursts;
  assign sense_in = force_en ? force_val :
                    ((cell_init != cell_tgt) && ((tgt_bursts - burst_base) >= need)) ? cell_tgt : cell_init;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Outcome model: already at target -> no pulses; else converges after 'nd' pulses if allowed.
  function automatic void model(input logic tgt, input logic init, input int nd,
                                output logic ok, output int tries);
    if (tgt == init) begin
      ok = 1'b1; tries = 0;
    end else if (nd <= MAX_TRIES) begin
      ok = 1'b1; tries = nd;
    end else begin
      ok = 1'b0; tries = MAX_TRIES;
    end
  endfunction

  task automatic run_req(input string tag, input logic tgt, input logic init, input int nd,
                         input logic exp_ok, input int exp_tries);
    int s_set, s_rst, s_rd, s_ex, s_gap, s_dv, lat, exp_lat;
    lat = 0;
    while (!req_ready && lat < 50) begin step(); lat++; end
    check({tag, "_ready"}, req_ready, 1);
    cell_tgt = tgt; cell_init = init; need = nd;
    burst_base = tgt ? set_bursts : reset_bursts;
    s_set = set_cyc; s_rst = reset_cyc; s_rd = read_cyc;
    s_ex = excl_viol; s_gap = gap_viol; s_dv = dv_cnt;
    req_target = tgt; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    lat = 1;
    while (!done_valid && lat < 400) begin step(); lat++; end
    check({tag, "_done_seen"}, done_valid, 1);
    check({tag, "_ok"}, done_ok, exp_ok);
    check({tag, "_tries"}, done_tries, exp_tries);
    exp_lat = (SETTLE_CYC + SAMPLE_CYC) * (exp_tries + 1) + exp_tries * (PULSE_CYC + 1) + 1;
    check({tag, "_latency"}, lat, exp_lat);
    step();
    check({tag, "_dv_1cyc"}, done_valid, 0);
    check({tag, "_ok_hold"}, done_ok, exp_ok);
    check({tag, "_tries_hold"}, done_tries, exp_tries);
    check({tag, "_set_cyc"}, set_cyc - s_set, tgt ? exp_tries * PULSE_CYC : 0);
    check({tag, "_reset_cyc"}, reset_cyc - s_rst, tgt ? 0 : exp_tries * PULSE_CYC);
    check({tag, "_read_cyc"}, read_cyc - s_rd, (exp_tries + 1) * (SETTLE_CYC + SAMPLE_CYC));
    check({tag, "_excl"}, excl_viol - s_ex, 0);
    check({tag, "_gap"}, gap_viol - s_gap, 0);
    check({tag, "_dv_count"}, dv_cnt - s_dv, 1);
  endtask

  // Forced sense levels: opposite of target while settling, pat during the sample window, target after.
  task automatic sample_seq(input string tag, input logic tgt, input logic [2:0] pat);
    int lat, idx, s_rd, exp_tries;
    logic decided;
`ifdef MEMR_READ_FILTER_EN
    decided = ((int'(pat[0]) + int'(pat[1]) + int'(pat[2])) >= 2);
`else
    decided = pat[0];
`endif
    exp_tries = (decided == tgt) ? 0 : 1;
    force_en = 1'b1; force_val = ~tgt;
    s_rd = read_cyc;
    req_target = tgt; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    lat = 1;
    while (!done_valid && lat < 200) begin
      idx = read_cyc - s_rd;
      if (idx <= SETTLE_CYC) force_val = ~tgt;
      else if (idx <= SETTLE_CYC + SAMPLE_CYC) force_val = pat[idx - SETTLE_CYC - 1];
      else force_val = tgt;
      step();
      lat++;
    end
    check({tag, "_done_seen"}, done_valid, 1);
    check({tag, "_ok"}, done_ok, 1);
    check({tag, "_tries"}, done_tries, exp_tries);
    step();
    force_en = 1'b0;
  endtask

  typedef struct {
    logic tgt;
    logic init;
    int   nd;
    logic exp_ok;
    int   exp_tries;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int s_dv, lat;
    logic m_ok;
    int m_tries;
    logic r_tgt, r_init;
    int r_nd;

    vecs[0] = '{1'b1, 1'b1, 0,  1'b1, 0};   // already matched
    vecs[1] = '{1'b0, 1'b1, 3,  1'b1, 3};   // converges on 3rd RESET pulse
    vecs[2] = '{1'b1, 1'b0, 99, 1'b0, 8};   // never converges
    vecs[3] = '{1'b0, 1'b0, 0,  1'b1, 0};   // already RESET
    vecs[4] = '{1'b1, 1'b0, 1,  1'b1, 1};   // single pulse
    vecs[5] = '{1'b1, 1'b0, 8,  1'b1, 8};   // converges on the last allowed pulse
    vecs[6] = '{1'b0, 1'b1, 9,  1'b0, 8};   // one pulse short

    // Reset state
    rst_n = 1'b0;
    repeat (3) step();
    check("rst_ready", req_ready, 0);
    check("rst_set", set_pulse, 0);
    check("rst_reset", reset_pulse, 0);
    check("rst_read", read_en, 0);
    check("rst_dv", done_valid, 0);
    check("rst_ok", done_ok, 0);
    check("rst_tries", done_tries, 0);
    rst_n = 1'b1;
    step();
    check("ready_after_rst", req_ready, 1);

    for (int i = 0; i < 7; i++)
      run_req($sformatf("vec%0d", i), vecs[i].tgt, vecs[i].init, vecs[i].nd,
              vecs[i].exp_ok, vecs[i].exp_tries);

    for (int i = 0; i < 20; i++) begin
      r_tgt = 1'($urandom_range(0, 1));
      r_init = 1'($urandom_range(0, 1));
      r_nd = $urandom_range(1, 11);
      model(r_tgt, r_init, r_nd, m_ok, m_tries);
      run_req($sformatf("rnd%0d", i), r_tgt, r_init, r_nd, m_ok, m_tries);
    end

    // Reset in the 2nd cycle of a SET pulse
    cell_tgt = 1'b1; cell_init = 1'b0; need = 99; burst_base = set_bursts;
    s_dv = dv_cnt;
    req_target = 1'b1; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    lat = 0;
    while (!set_pulse && lat < 100) begin step(); lat++; end
    check("rstp_pulse_seen", set_pulse, 1);
    step();
    check("rstp_pulse_2nd", set_pulse, 1);
    rst_n = 1'b0;
    step();
    check("rstp_pulse_cut", set_pulse, 0);
    check("rstp_read_low", read_en, 0);
    check("rstp_ready_low", req_ready, 0);
    rst_n = 1'b1;
    step();
    check("rstp_ready_after", req_ready, 1);
    check("rstp_ok_cleared", done_ok, 0);
    check("rstp_tries_cleared", done_tries, 0);
    repeat (3) step();
    check("rstp_no_done", dv_cnt - s_dv, 0);

    // Read sampling point / majority filter
    sample_seq("samp_101_t1", 1'b1, 3'b101);
    sample_seq("samp_110_t1", 1'b1, 3'b110);
    sample_seq("samp_010_t0", 1'b0, 3'b010);
    sample_seq("samp_001_t1", 1'b1, 3'b001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
